// File: rtl/xm_mem_interface.sv
`default_nettype none
// ============================================================================
// xm_mem_interface : req/ack memory bus engine with byte-lane steering and
//                    access timeout for the XMakina control plane.
// Revision: 1.0
// ============================================================================
module xm_mem_interface #(
   parameter int WORD    = 16,
   parameter int TIMEOUT = 64,
   parameter int CW      = 7
) (
   input  logic            clk_i,
   input  logic            arst_i,
   input  logic            memEn_i,
   input  logic            memRW_i,
   input  logic            byteOp_i,
   input  logic [WORD-1:0] addr_i,
   input  logic [WORD-1:0] wdata_i,
   output logic            memBusy_o,
   output logic            memWr_o,
   output logic [WORD-1:0] rdata_o,
   output logic            busErr_o,
   output logic            bus_req_o,
   output logic            bus_we_o,
   output logic [1:0]      bus_be_o,
   output logic [WORD-1:0] bus_addr_o,
   output logic [WORD-1:0] bus_wdata_o,
   input  logic [WORD-1:0] bus_rdata_i,
   input  logic            bus_ack_i
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

   logic [1:0]      state;
   logic            req_rw;
   logic            req_byte;
   logic [WORD-1:0] req_addr;
   logic [WORD-1:0] req_wdata;
   logic [CW-1:0]   cnt;
   logic            err;
   logic [WORD-1:0] rdata;

   logic            in_req;
   logic            in_done;
   logic [1:0]      be;
   logic [WORD-1:0] wdata_fmt;
   logic [WORD-1:0] rdata_sel;

   assign in_req  = (state == REQ);
   assign in_done = (state == DONE);

   always_comb begin
      be        = 2'b11;
      wdata_fmt = req_wdata;
      rdata_sel = bus_rdata_i;
      if (req_byte) begin
         be        = req_addr[0] ? 2'b10 : 2'b01;
         wdata_fmt = {req_wdata[7:0], req_wdata[7:0]};
         rdata_sel = {8'h00, (req_addr[0] ? bus_rdata_i[15:8] : bus_rdata_i[7:0])};
      end
   end

   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         state     <= IDLE;
         req_rw    <= 1'b0;
         req_byte  <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         cnt       <= '0;
         err       <= 1'b0;
         rdata     <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (memEn_i) begin
                  req_rw    <= memRW_i;
                  req_byte  <= byteOp_i;
                  req_addr  <= addr_i;
                  req_wdata <= wdata_i;
                  cnt       <= '0;
                  err       <= 1'b0;
                  state     <= REQ;
               end else begin
                  state     <= IDLE;
               end
            end
            REQ: begin
               // Ack takes priority over an expiring counter.
               if (bus_ack_i) begin
                  state <= DONE;
                  err   <= 1'b0;
                  if (!req_rw) rdata <= rdata_sel;
               end else if (cnt == LAST_CNT) begin
                  state <= DONE;
                  err   <= 1'b1;
                  if (!req_rw) rdata <= '0;
               end else begin
                  cnt   <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bus outputs are only presented while the request is outstanding.
   assign bus_req_o   = in_req;
   assign bus_we_o    = in_req & req_rw;
   assign bus_be_o    = in_req ? be : 2'b00;
   assign bus_addr_o  = in_req ? {req_addr[WORD-1:1], 1'b0} : '0;
   assign bus_wdata_o = in_req ? wdata_fmt : '0;

   assign memBusy_o = in_req | (memEn_i & (state == IDLE || in_done));
   assign memWr_o   = in_done & ~req_rw & ~err;
   assign busErr_o  = in_done & err;
   assign rdata_o   = rdata;

endmodule
`default_nettype wire

// File: tb/tb_xm_mem_interface.sv
`default_nettype none
// Self-checking bench for xm_mem_interface: directed table, corner sequences
// and random accesses checked against a transaction-level model.
module tb_xm_mem_interface;

   localparam int WORD    = 16;
   localparam int TIMEOUT = 64;
   localparam int CW      = 7;

   logic            clk = 1'b0;
   logic            arst = 1'b0;
   logic            mem_en = 1'b0, mem_rw = 1'b0, byte_op = 1'b0;
   logic [WORD-1:0] addr = '0, wdata = '0, bus_rdata = '0;
   logic            bus_ack = 1'b0;
   logic            mem_busy, mem_wr, bus_err, bus_req, bus_we;
   logic [1:0]      bus_be;
   logic [WORD-1:0] rdata, bus_addr, bus_wdata;

   xm_mem_interface #(.WORD(WORD), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
      .clk_i(clk), .arst_i(arst), .memEn_i(mem_en), .memRW_i(mem_rw),
      .byteOp_i(byte_op), .addr_i(addr), .wdata_i(wdata),
      .memBusy_o(mem_busy), .memWr_o(mem_wr), .rdata_o(rdata),
      .busErr_o(bus_err), .bus_req_o(bus_req), .bus_we_o(bus_we),
      .bus_be_o(bus_be), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
      .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
   endtask

   typedef struct {
      logic        rw;
      logic        bop;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] brd;
      int          waits;   // ack after this many REQ cycles; >= TIMEOUT means never
      logic [1:0]  exp_be;
      logic [15:0] exp_addr;
      logic [15:0] exp_wdata;
      logic [15:0] exp_rdata;
      logic        exp_wr;
      logic        exp_err;
   } rec_t;

   // Transaction-level reference: outcome of one access given the previous read result.
   function automatic rec_t model(input logic rw, input logic bop, input logic [15:0] a,
                                  input logic [15:0] wd, input logic [15:0] brd,
                                  input int waits, input logic [15:0] prev);
      rec_t r;
      bit timed;
      timed       = (waits >= TIMEOUT);
      r.rw = rw; r.bop = bop; r.addr = a; r.wdata = wd; r.brd = brd; r.waits = waits;
      r.exp_addr  = a & 16'hFFFE;
      r.exp_be    = bop ? 2'(1 << a[0]) : 2'd3;
      r.exp_wdata = bop ? 16'((wd & 16'h00FF) * 16'h0101) : wd;
      r.exp_err   = timed;
      r.exp_wr    = !rw && !timed;
      if (rw)         r.exp_rdata = prev;
      else if (timed) r.exp_rdata = 16'h0000;
      else if (bop)   r.exp_rdata = (brd >> (8 * a[0])) & 16'h00FF;
      else            r.exp_rdata = brd;
      return r;
   endfunction

   task automatic run_access(input rec_t r);
      bit last;
      @(posedge clk); #1;
      mem_en = 1'b1; mem_rw = r.rw; byte_op = r.bop; addr = r.addr; wdata = r.wdata;
      bus_ack = 1'b0;
      #2;
      chk("req_busy", mem_busy, 1'b1);
      chk("req_no_bus", bus_req, 1'b0);
      for (int k = 0; k < TIMEOUT; k++) begin
         last = (k == r.waits) || (k == TIMEOUT - 1);
         @(posedge clk); #1;
         // Requests and field changes during REQ must be ignored.
         mem_en = !last; mem_rw = 1'($urandom); byte_op = 1'($urandom);
         addr = 16'($urandom); wdata = 16'($urandom);
         bus_ack = (k == r.waits);
         bus_rdata = bus_ack ? r.brd : 16'($urandom);
         #2;
         chk("bus_req", bus_req, 1'b1);
         chk("busy_req", mem_busy, 1'b1);
         chk("bus_we", bus_we, r.rw);
         chk("bus_be", bus_be, r.exp_be);
         chk("bus_addr", bus_addr, r.exp_addr);
         if (r.rw) chk("bus_wdata", bus_wdata, r.exp_wdata);
         if (k == 0) chk("no_pulse_req", {mem_wr, bus_err}, 2'b00);
         if (last) break;
      end
      @(posedge clk); #1;
      mem_en = 1'b0; bus_ack = 1'($urandom);
      #2;
      chk("done_req_low", bus_req, 1'b0);
      chk("done_memwr", mem_wr, r.exp_wr);
      chk("done_buserr", bus_err, r.exp_err);
      chk("done_rdata", rdata, r.exp_rdata);
      chk("done_busy", mem_busy, 1'b0);
   endtask

   rec_t vec[8];
   logic [15:0] model_rd;

   initial begin
      // rw bop addr wdata brd waits be addr wdata rdata wr err
      vec[0] = '{1'b0, 1'b0, 16'h1235, 16'h0000, 16'hBEEF, 0,   2'b11, 16'h1234, 16'h0000, 16'hBEEF, 1'b1, 1'b0};
      vec[1] = '{1'b0, 1'b1, 16'h0041, 16'h0000, 16'hA55A, 3,   2'b10, 16'h0040, 16'h0000, 16'h00A5, 1'b1, 1'b0};
      vec[2] = '{1'b1, 1'b1, 16'h0100, 16'h12C3, 16'h0000, 1,   2'b01, 16'h0100, 16'hC3C3, 16'h00A5, 1'b0, 1'b0};
      vec[3] = '{1'b1, 1'b0, 16'h2223, 16'h5A5A, 16'h0000, 2,   2'b11, 16'h2222, 16'h5A5A, 16'h00A5, 1'b0, 1'b0};
      vec[4] = '{1'b0, 1'b1, 16'h0100, 16'h0000, 16'h1234, 0,   2'b01, 16'h0100, 16'h0000, 16'h0034, 1'b1, 1'b0};
      vec[5] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h7777, 64,  2'b11, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1};
      vec[6] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hCAFE, 63,  2'b11, 16'h0020, 16'h0000, 16'hCAFE, 1'b1, 1'b0};
      vec[7] = '{1'b1, 1'b1, 16'h0033, 16'h00AB, 16'h0000, 100, 2'b10, 16'h0032, 16'hABAB, 16'hCAFE, 1'b0, 1'b1};

      #3;
      chk("rst_outputs", {mem_busy, mem_wr, bus_err, bus_req, bus_we, bus_be}, 7'd0);
      chk("rst_rdata", rdata, 16'h0);
      chk("rst_bus_addr", bus_addr, 16'h0);
      chk("rst_bus_wdata", bus_wdata, 16'h0);
      @(posedge clk); #1 arst = 1'b1;

      for (int i = 0; i < 8; i++) run_access(vec[i]);
      model_rd = 16'hCAFE;

      // Back-to-back: new byte write issued during DONE of a word read.
      @(posedge clk); #1;
      mem_en = 1'b1; mem_rw = 1'b0; byte_op = 1'b0; addr = 16'h0300; bus_ack = 1'b0;
      @(posedge clk); #1;
      mem_en = 1'b0; bus_ack = 1'b1; bus_rdata = 16'h1111;
      @(posedge clk); #1;
      mem_en = 1'b1; mem_rw = 1'b1; byte_op = 1'b1; addr = 16'h0305; wdata = 16'h77AB; bus_ack = 1'b0;
      #2;
      chk("b2b_done_busy", mem_busy, 1'b1);
      chk("b2b_done_memwr", mem_wr, 1'b1);
      chk("b2b_done_rdata", rdata, 16'h1111);
      chk("b2b_done_req", bus_req, 1'b0);
      @(posedge clk); #1;
      mem_en = 1'b0; addr = 16'h0; wdata = 16'h0; bus_ack = 1'b1;
      #2;
      chk("b2b_req", bus_req, 1'b1);
      chk("b2b_fields", {bus_we, bus_be, bus_addr, bus_wdata}, {1'b1, 2'b10, 16'h0304, 16'hABAB});
      @(posedge clk); #1 bus_ack = 1'b0;
      #2;
      chk("b2b_write_done", {mem_wr, bus_err, mem_busy}, 3'b000);
      chk("b2b_rdata_kept", rdata, 16'h1111);

      // Reset in the middle of an access.
      @(posedge clk); #1;
      mem_en = 1'b1; mem_rw = 1'b0; byte_op = 1'b0; addr = 16'h0444;
      @(posedge clk); #1;
      mem_en = 1'b0;
      #1;
      chk("mid_req_up", bus_req, 1'b1);
      arst = 1'b0;
      #1;
      chk("mid_rst_req", bus_req, 1'b0);
      chk("mid_rst_rdata", rdata, 16'h0);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #3;
         chk("mid_rst_pulses", {mem_wr, bus_err, mem_busy}, 3'b000);
      end
      #1 arst = 1'b1;
      run_access(model(1'b0, 1'b1, 16'h0451, 16'h0, 16'h9C3E, 1, 16'h0));
      model_rd = 16'h009C;

      // Random accesses against the transaction model.
      for (int i = 0; i < 24; i++) begin
         rec_t r;
         int w;
         w = ($urandom_range(0, 7) == 0) ? TIMEOUT + 2 : int'($urandom_range(0, 5));
         r = model(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), w, model_rd);
         run_access(r);
         model_rd = r.exp_rdata;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/xm_mem_interface.md
Name: xm_mem_interface

Overview:
- Bus-side memory access engine downstream of the XMakina control plane.
- Accepts the control plane's memory request (enable, read/write, byte/word, address, write data) and runs a req/ack handshake on the external memory bus.
- Handles byte-lane steering and times out stalled accesses.
- Returns busy and read-data-valid status that the control plane consumes as memBusy and memWr.

Parameters:
- WORD, 16, data/address width in bits.
- TIMEOUT, 64, maximum cycles in REQ without ack before abort (>=2).
- CW, 7, timeout counter width (must hold TIMEOUT).

Ports:
- clk_i  in  1  system clock, rising edge.
- arst_i  in  1  asynchronous, active-low reset.
- memEn_i  in  1  access request from control plane (level).
- memRW_i  in  1  1 = write, 0 = read.
- byteOp_i  in  1  1 = byte access, 0 = word access.
- addr_i  in  WORD  byte address.
- wdata_i  in  WORD  write data; byte writes use bits [7:0].
- memBusy_o  out  1  access in progress; control plane stalls.
- memWr_o  out  1  one-cycle pulse: rdata_o valid, load into register file.
- rdata_o  out  WORD  read result.
- busErr_o  out  1  one-cycle pulse: access aborted by timeout.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write enable.
- bus_be_o  out  2  byte enables; [0] = low byte (even address), [1] = high byte.
- bus_addr_o  out  WORD  word-aligned bus address (bit 0 always 0).
- bus_wdata_o  out  WORD  bus write data.
- bus_rdata_i  in  WORD  bus read data, valid with ack.
- bus_ack_i  in  1  access complete.

Behaviour:
- Reset (arst_i low, asynchronous):
  - state = IDLE.
  - All outputs 0, including rdata_o, the latched request and the counter.
  - Reset mid-access drops bus_req_o immediately; no memWr_o or busErr_o pulse follows.
- FSM states: IDLE, REQ, DONE.
  - IDLE: memEn_i=1 latches memRW_i, byteOp_i, addr_i and wdata_i; counter cleared; next state REQ.
  - REQ: bus_req_o=1 and bus outputs driven from the latched request.
    - bus_ack_i=1 -> DONE.
    - Counter reaches TIMEOUT-1 without ack -> DONE with error flag set.
    - Otherwise counter increments.
  - DONE (exactly one cycle):
    - bus_req_o=0.
    - memWr_o=1 if the access was a read without error.
    - busErr_o=1 if the access timed out.
    - memEn_i=1 latches a new request and goes to REQ (back-to-back); else IDLE.
- memBusy_o (combinational) = (state==REQ) | (memEn_i & state∈{IDLE,DONE}). The cycle an access is requested is already busy. Busy is 0 in DONE when no new request is made.
- memEn_i is ignored while in REQ; latched fields never change mid-access.
- Minimum latency: memEn_i in cycle 0 -> REQ in cycle 1 -> ack in cycle 1 -> DONE / memWr_o in cycle 2.
- Address: bus_addr_o = {addr[WORD-1:1],1'b0}. Word accesses ignore addr[0] (aligned down).
- Byte enables:
  - Word access: bus_be_o = 2'b11.
  - Byte access: bus_be_o = addr[0] ? 2'b10 : 2'b01.
- Write data:
  - Word write: bus_wdata_o = wdata.
  - Byte write: bus_wdata_o = {wdata[7:0], wdata[7:0]}.
- Read data, captured on the ack cycle:
  - Word read: rdata_o = bus_rdata_i.
  - Byte read: rdata_o = {8'h00, selected lane}, where the lane is [15:8] if addr[0]=1 and [7:0] otherwise.
  - rdata_o holds until the next read completes; it is unchanged by writes.
  - A timed-out read sets rdata_o = 0.
- bus_ack_i outside REQ is ignored.
- Ack on the same cycle the counter hits TIMEOUT-1: the ack wins, no error is flagged.

Test Plan:
- Word read, ack in first REQ cycle: addr=0x1235, bus_rdata=0xBEEF -> bus_addr=0x1234, be=11, we=0; memWr_o pulses in cycle 2; rdata_o=0xBEEF; busy high for cycles 0-1.
- Byte read, odd address: addr=0x0041, bus_rdata=0xA55A, ack after 3 wait cycles -> be=10; rdata_o=0x00A5; memWr_o pulses once; busy high for 5 cycles.
- Byte write, even address: addr=0x0100, wdata=0x12C3 -> we=1, be=01, bus_wdata=0xC3C3; DONE with memWr_o=0; rdata_o unchanged.
- Timeout: read with no ack, TIMEOUT=64 -> bus_req drops after 64 REQ cycles; busErr_o pulses; rdata_o=0; memWr_o stays 0. Repeat with ack on the final count -> no error.
- Back-to-back: memEn_i held through DONE with a new write -> no IDLE cycle; bus_req re-asserts the cycle after DONE; memBusy_o low only... never low; second request fields latched correctly.
- Reset mid-access: arst_i low during REQ -> bus_req_o=0 immediately; state IDLE; no pulses; a fresh read after release completes normally.
